// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit : EX-stage MULT/MULTU/DIV/DIVU unit owning HI/LO (negedge)
// Revision 1.0
// ============================================================================
module ex_muldiv_unit #(
   parameter int MUL_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        cancel,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   localparam logic [5:0] C_MUL_LAST = 6'(MUL_LATENCY - 1);
   localparam logic [5:0] C_DIV_LAST = 6'd31;

   state_t      r_state, w_state_next;
   logic        w_issue, w_mul_wr, w_fix_wr, w_mt_ok;

   logic [5:0]  r_count;
   logic [31:0] r_a, r_b;
   logic        r_signed, r_div0, r_neg_q, r_neg_r;
   logic [31:0] r_quo, r_rem, r_dvsr;
   logic [31:0] r_hi, r_lo;
   logic        r_done;

   logic        w_op_signed;
   logic [31:0] w_abs_a, w_abs_b;
   logic [63:0] w_ext_a, w_ext_b, w_prod;
   logic [32:0] w_trial, w_diff;
   logic [31:0] w_q_fix, w_r_fix;

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_mul_wr     = 1'b0;
      w_fix_wr     = 1'b0;
      w_mt_ok      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_mt_ok = 1'b1;
            if (start && !cancel) begin
               w_issue = 1'b1;
               if (!op_i[1])            w_state_next = S_MUL;
               else if (rt_val == 32'd0) w_state_next = S_FIX;
               else                      w_state_next = S_DIV;
            end
         end
         S_MUL: begin
            if (cancel) w_state_next = S_IDLE;
            else if (r_count == C_MUL_LAST) begin
               w_mul_wr     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_DIV: begin
            if (cancel)                     w_state_next = S_IDLE;
            else if (r_count == C_DIV_LAST) w_state_next = S_FIX;
         end
         S_FIX: begin
            if (cancel) w_state_next = S_IDLE;
            else begin
               w_fix_wr     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   assign w_op_signed = ~op_i[0];
   assign w_abs_a     = (w_op_signed && rs_val[31]) ? -rs_val : rs_val;
   assign w_abs_b     = (w_op_signed && rt_val[31]) ? -rt_val : rt_val;

   assign w_ext_a = {{32{r_signed & r_a[31]}}, r_a};
   assign w_ext_b = {{32{r_signed & r_b[31]}}, r_b};
   assign w_prod  = w_ext_a * w_ext_b;

   // Bit 32 of the difference is the borrow: set means trial < divisor.
   assign w_trial = {r_rem, r_quo[31]};
   assign w_diff  = w_trial - {1'b0, r_dvsr};

   assign w_q_fix = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix = r_neg_r ? -r_rem : r_rem;

   always_ff @(negedge clk) begin
      if (rst) begin
         r_count  <= 6'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_signed <= 1'b0;
         r_div0   <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_quo    <= 32'd0;
         r_rem    <= 32'd0;
         r_dvsr   <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_mul_wr | w_fix_wr;

         if (w_issue) begin
            r_a      <= rs_val;
            r_b      <= rt_val;
            r_signed <= w_op_signed;
            r_count  <= 6'd0;
            r_div0   <= op_i[1] && (rt_val == 32'd0);
            r_neg_q  <= w_op_signed & (rs_val[31] ^ rt_val[31]);
            r_neg_r  <= w_op_signed & rs_val[31];
            r_quo    <= w_abs_a;
            r_rem    <= 32'd0;
            r_dvsr   <= w_abs_b;
         end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_count <= r_count + 6'd1;
         end

         if (r_state == S_DIV) begin
            if (!w_diff[32]) begin
               r_rem <= w_diff[31:0];
               r_quo <= {r_quo[30:0], 1'b1};
            end else begin
               r_rem <= w_trial[31:0];
               r_quo <= {r_quo[30:0], 1'b0};
            end
         end

         if (w_mul_wr) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end else if (w_fix_wr) begin
            r_hi <= r_div0 ? r_a : w_r_fix;
            r_lo <= r_div0 ? 32'hFFFF_FFFF : w_q_fix;
         end else if (w_mt_ok) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = (r_state != S_IDLE);
   assign done = r_done;

endmodule
`default_nettype wire
